mc_datapath: RTL and testbench
==============================

# mc_datapath

Register-level datapath of the multicycle MIPS core. Sits directly downstream of the multicycle control unit: it consumes that unit's 16 control signals every cycle and returns the instruction opcode that drives the controller's next-state logic. It holds PC, IR, MDR, A, B, ALUOut, the 32x32 register file, the ALU with its ALU-control decode, and the unified-memory interface.

## Interface

- RESET_PC, 32'h0000_0000, PC value loaded on reset.

- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, RegDst, ALUSrcA  in  1 each  controller strobes.
- PCSource  in  2  {PCSource1, PCSource0}.
- ALUOp  in  2  {ALUOp1, ALUOp0}.
- ALUSrcB  in  2  {ALUSrcB1, ALUSrcB0}.
- mem_addr  out  32  = IorD ? ALUOut : PC.
- mem_wdata  out  32  = B.
- mem_re  out  1  = MemRead.
- mem_we  out  1  = MemWrite.
- mem_rdata  in  32  combinational read data, valid in the same cycle as mem_addr.
- op  out  6  IR[31:26], fed to the controller.
- zero  out  1  ALU result == 0.
- pc  out  32  current PC (debug).
- ir  out  32  current IR (debug).

## Operation

- On every edge:
  - MDR <= mem_rdata.
  - A <= rf[IR[25:21]].
  - B <= rf[IR[20:16]].
  - ALUOut <= ALU result.
- IR <= mem_rdata when IRWrite.
- PC <= PC-next when PCWrite | (PCWriteCond & zero).
- ALU A operand: ALUSrcA ? A : PC.
- ALU B operand by ALUSrcB:
  - 00: B
  - 01: 32'd4
  - 10: sext(IR[15:0])
  - 11: sext(IR[15:0]) << 2
- ALU control:
  - ALUOp 00: add.
  - ALUOp 01: sub.
  - ALUOp 10: decode funct IR[5:0]:
    - 100000 add
    - 100010 sub
    - 100100 and
    - 100101 or
    - 101010 slt (signed)
    - any other funct: add
  - ALUOp 11: add.
- Arithmetic: 32-bit, modulo 2^32, no overflow detection. slt yields 32'd1 or 32'd0.
- PC-next by PCSource:
  - 00: ALU result
  - 01: ALUOut
  - 10: {PC[31:28], IR[25:0], 2'b00}
  - 11: ALU result
- Register file:
  - Write on edge when RegWrite.
  - Write address: RegDst ? IR[15:11] : IR[20:16].
  - Write data: MemtoReg ? MDR : ALUOut.
  - Writes to register 0 are discarded; register 0 always reads 0.
  - Reads are combinational.
- Supported instruction flows, as driven by the controller:
  - R-type: fetch, decode, execute, R-complete.
  - lw: fetch, decode, memaddr, memread, writeback.
  - sw: fetch, decode, memaddr, memwrite.
  - beq: fetch, decode, branch.
  - j: fetch, decode, jump.

## Timing

- Reset, at the edge where reset=1:
  - PC = RESET_PC.
  - IR, MDR, A, B, ALUOut and all 32 registers = 0.
  - Resulting outputs: op=0, ir=0, pc=RESET_PC, mem_addr=RESET_PC when IorD=0.
  - Reset mid-instruction discards all in-flight state. There are no partial writes on the reset edge; reset has priority over RegWrite, IRWrite and PCWrite.
- Latency:
  - Control inputs take effect at the edge ending the cycle in which they are presented.
  - The new op is visible the cycle after IRWrite.
- Read/write same cycle:
  - A register-file read returns the old value when that register is written in the same cycle.
  - A and B captured on that edge hold the old value.
- Simultaneous PCWrite and PCWriteCond: the PC is written when either term is true; there is no conflict.
- mem_we and mem_re are pure pass-through, with no added cycle.
- Memory is assumed zero-wait. There is no stall handshake.

## Structure

- Package mc_pkg:
  - ALUOp encodings.
  - Internal 3-bit ALU-control codes (ADD, SUB, AND, OR, SLT).
  - funct constants.
  - Opcode constants: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, J 000010.
  - PCSource and ALUSrcB encodings.
- Sub-module mc_regfile: 32x32, two combinational read ports, one synchronous write port, register 0 forced to zero, synchronous reset clearing all entries.
- ALU and ALU-control stay inline in mc_datapath.

## Test plan

- Reset: hold reset for 2 cycles with RESET_PC=0 -> pc=0, ir=0, op=0, mem_addr=0; a RegWrite asserted during reset has no effect.
- Fetch: state-0 controls, mem_rdata=32'h8C22_0004 -> ir=32'h8C22_0004, op=6'b100011, pc=4.
- lw followed by R-type add:
  - Setup: memory word at address 4 = 5, at address 8 = 7; $2 loaded with 5, $3 with 7.
  - Run 0x00433020 (add $6,$2,$3) through states 0,1,6,7 -> $6=12.
  - Replace with sub and slt variants -> $6 = 32'hFFFF_FFFE and $6 = 1 respectively.
- beq:
  - Taken: beq at pc=8 with equal operands and offset 3 -> pc=24.
  - Not taken: unequal operands -> pc=12.
- Jump: IR=32'h0800_0010 at pc=32'h1000_0040 -> pc=32'h1000_0040.
- sw and register 0:
  - sw $2,8($0) -> during the memwrite state mem_addr=8, mem_wdata=5, mem_we=1.
  - An R-type add with rd=0 -> register 0 still reads 0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS datapath: controller field codes,
// internal ALU-control codes, funct and opcode constants.
package mc_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_ADD2  = 2'b11
    } aluop_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } aluctl_e;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10,
        PCSRC_ALU2   = 2'b11
    } pcsrc_e;

    typedef enum logic [1:0] {
        SRCB_B      = 2'b00,
        SRCB_FOUR   = 2'b01,
        SRCB_IMM    = 2'b10,
        SRCB_IMM_SH = 2'b11
    } srcb_e;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/mc_mem_if.sv
// Unified instruction/data memory port; zero-wait, combinational read data.
interface mc_mem_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_rdata;

    modport master (output mem_addr, mem_wdata, mem_re, mem_we, input mem_rdata);
    modport slave  (input mem_addr, mem_wdata, mem_re, mem_we, output mem_rdata);
endinterface

// File: rtl/mc_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write
// port, register 0 hard-wired to zero, synchronous clear on reset.
module mc_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);
    logic [31:0] regs_reg [32];

    // Entry 0 has a write condition that is constant false, so it stays zero.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_reg
            always_ff @(posedge clk) begin
                if (reset) begin
                    regs_reg[gi] <= '0;
                end else if (we && (gi != 0) && (wa == 5'(gi))) begin
                    regs_reg[gi] <= wd;
                end
            end
        end
    endgenerate

    assign rd1 = regs_reg[ra1];
    assign rd2 = regs_reg[ra2];
endmodule

// File: rtl/mc_datapath.sv
// Multicycle MIPS datapath: PC, IR, MDR, A, B, ALUOut, register file, ALU and
// ALU-control decode, driven by the external multicycle controller.
module mc_datapath
    import mc_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         PCWrite,
    input  logic         PCWriteCond,
    input  logic         IorD,
    input  logic         MemRead,
    input  logic         MemWrite,
    input  logic         IRWrite,
    input  logic         MemtoReg,
    input  logic         RegWrite,
    input  logic         RegDst,
    input  logic         ALUSrcA,
    input  logic [1:0]   PCSource,
    input  logic [1:0]   ALUOp,
    input  logic [1:0]   ALUSrcB,
    mc_mem_if.master     mem,
    output logic [5:0]   op,
    output logic         zero,
    output logic [31:0]  pc,
    output logic [31:0]  ir
);
    logic [31:0] pc_reg, ir_reg, mdr_reg, a_reg, b_reg, aluout_reg;
    logic [31:0] rf_rd1, rf_rd2;
    logic [31:0] imm_ext;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [31:0] pc_next;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        pc_en;
    aluctl_e     alu_ctl;

    assign rf_wa = RegDst   ? ir_reg[15:11] : ir_reg[20:16];
    assign rf_wd = MemtoReg ? mdr_reg       : aluout_reg;

    mc_regfile u_regfile (
        .clk   (clk),
        .reset (reset),
        .ra1   (ir_reg[25:21]),
        .ra2   (ir_reg[20:16]),
        .rd1   (rf_rd1),
        .rd2   (rf_rd2),
        .we    (RegWrite),
        .wa    (rf_wa),
        .wd    (rf_wd)
    );

    assign imm_ext = sext16(ir_reg[15:0]);
    assign alu_a   = ALUSrcA ? a_reg : pc_reg;

    always_comb begin
        alu_b = b_reg;
        case (ALUSrcB)
            SRCB_B:      alu_b = b_reg;
            SRCB_FOUR:   alu_b = 32'd4;
            SRCB_IMM:    alu_b = imm_ext;
            SRCB_IMM_SH: alu_b = {imm_ext[29:0], 2'b00};
            default:     alu_b = b_reg;
        endcase
    end

    // Unrecognised funct codes fall back to add rather than a don't-care.
    always_comb begin
        alu_ctl = ALU_ADD;
        case (ALUOp)
            ALUOP_SUB: alu_ctl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (ir_reg[5:0])
                    FUNCT_SUB: alu_ctl = ALU_SUB;
                    FUNCT_AND: alu_ctl = ALU_AND;
                    FUNCT_OR:  alu_ctl = ALU_OR;
                    FUNCT_SLT: alu_ctl = ALU_SLT;
                    default:   alu_ctl = ALU_ADD;
                endcase
            end
            default: alu_ctl = ALU_ADD;
        endcase
    end

    always_comb begin
        alu_result = alu_a + alu_b;
        case (alu_ctl)
            ALU_ADD: alu_result = alu_a + alu_b;
            ALU_SUB: alu_result = alu_a - alu_b;
            ALU_AND: alu_result = alu_a & alu_b;
            ALU_OR:  alu_result = alu_a | alu_b;
            ALU_SLT: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_result = alu_a + alu_b;
        endcase
    end

    assign zero = (alu_result == 32'd0);

    always_comb begin
        pc_next = alu_result;
        case (PCSource)
            PCSRC_ALU:    pc_next = alu_result;
            PCSRC_ALUOUT: pc_next = aluout_reg;
            PCSRC_JUMP:   pc_next = {pc_reg[31:28], ir_reg[25:0], 2'b00};
            PCSRC_ALU2:   pc_next = alu_result;
            default:      pc_next = alu_result;
        endcase
    end

    assign pc_en = PCWrite | (PCWriteCond & zero);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg     <= RESET_PC;
            ir_reg     <= '0;
            mdr_reg    <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            aluout_reg <= '0;
        end else begin
            mdr_reg    <= mem.mem_rdata;
            a_reg      <= rf_rd1;
            b_reg      <= rf_rd2;
            aluout_reg <= alu_result;
            if (IRWrite) ir_reg <= mem.mem_rdata;
            if (pc_en)   pc_reg <= pc_next;
        end
    end

    assign mem.mem_addr  = IorD ? aluout_reg : pc_reg;
    assign mem.mem_wdata = b_reg;
    assign mem.mem_re    = MemRead;
    assign mem.mem_we    = MemWrite;

    assign op = ir_reg[31:26];
    assign pc = pc_reg;
    assign ir = ir_reg;
endmodule

// File: tb/tb_mc_datapath.sv
// Bench for mc_datapath: directed instruction flows plus random control
// traffic, checked every cycle against an instruction-level register model.
module tb_mc_datapath;
    import mc_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic MemtoReg, RegWrite, RegDst, ALUSrcA;
    logic [1:0] PCSource, ALUOp, ALUSrcB;
    logic [5:0]  op;
    logic        zero;
    logic [31:0] pc, ir;

    mc_mem_if mem ();

    mc_datapath dut (
        .clk(clk), .reset(reset),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .RegDst(RegDst),
        .ALUSrcA(ALUSrcA), .PCSource(PCSource), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
        .mem(mem), .op(op), .zero(zero), .pc(pc), .ir(ir)
    );

    typedef struct packed {
        logic pcw, pcwc, iord, mr, mw, irw, m2r, rw, rdst, srca;
        logic [1:0] pcsrc, aluop, srcb;
    } ctl_t;

    // Controller states of the classic multicycle MIPS FSM.
    localparam ctl_t S0 = '{pcw:1'b1, mr:1'b1, irw:1'b1, srcb:2'b01, default:'0};
    localparam ctl_t S1 = '{srcb:2'b11, default:'0};
    localparam ctl_t S2 = '{srca:1'b1, srcb:2'b10, default:'0};
    localparam ctl_t S3 = '{mr:1'b1, iord:1'b1, default:'0};
    localparam ctl_t S4 = '{rw:1'b1, m2r:1'b1, default:'0};
    localparam ctl_t S5 = '{mw:1'b1, iord:1'b1, default:'0};
    localparam ctl_t S6 = '{srca:1'b1, aluop:2'b10, default:'0};
    localparam ctl_t S7 = '{rw:1'b1, rdst:1'b1, default:'0};
    localparam ctl_t S8 = '{srca:1'b1, aluop:2'b01, pcwc:1'b1, pcsrc:2'b01, default:'0};
    localparam ctl_t S9 = '{pcw:1'b1, pcsrc:2'b10, default:'0};
    localparam ctl_t SPC = '{pcw:1'b1, srca:1'b1, srcb:2'b10, default:'0};
    localparam ctl_t SRW = '{rw:1'b1, irw:1'b1, pcw:1'b1, default:'0};

    int n_vec = 0;
    int n_err = 0;

    // Architectural model state
    logic [31:0] m_pc, m_ir, m_mdr, m_a, m_b, m_aluout;
    logic [31:0] m_rf [32];
    logic [31:0] e_res, e_addr;
    ctl_t        cur_c;
    logic [31:0] cur_rd;
    logic        cur_rst;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] alu_model(input logic [1:0] aluop, input logic [5:0] funct,
                                              input logic [31:0] x, input logic [31:0] y);
        if (aluop == 2'b01) return x - y;
        if (aluop == 2'b10) begin
            if (funct == 6'h22) return x - y;
            if (funct == 6'h24) return x & y;
            if (funct == 6'h25) return x | y;
            if (funct == 6'h2a) return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
        end
        return x + y;
    endfunction

    function automatic logic [31:0] operand_b(input logic [1:0] sel);
        logic [31:0] imm;
        imm = {{16{m_ir[15]}}, m_ir[15:0]};
        if (sel == 2'b00) return m_b;
        if (sel == 2'b01) return 32'd4;
        if (sel == 2'b10) return imm;
        return imm * 4;
    endfunction

    task automatic model_reset();
        m_pc = RESET_PC; m_ir = '0; m_mdr = '0; m_a = '0; m_b = '0; m_aluout = '0;
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
    endtask

    task automatic model_edge();
        logic [31:0] na, nb, npc;
        logic [4:0]  wa;
        if (cur_rst) begin
            model_reset();
            return;
        end
        na  = m_rf[m_ir[25:21]];
        nb  = m_rf[m_ir[20:16]];
        npc = m_pc;
        if (cur_c.pcw || (cur_c.pcwc && e_res == 0)) begin
            if (cur_c.pcsrc == 2'b01)      npc = m_aluout;
            else if (cur_c.pcsrc == 2'b10) npc = {m_pc[31:28], m_ir[25:0], 2'b00};
            else                           npc = e_res;
        end
        if (cur_c.rw) begin
            wa = cur_c.rdst ? m_ir[15:11] : m_ir[20:16];
            if (wa != 0) m_rf[wa] = cur_c.m2r ? m_mdr : m_aluout;
        end
        m_pc = npc;
        m_aluout = e_res;
        m_mdr = cur_rd;
        if (cur_c.irw) m_ir = cur_rd;
        m_a = na;
        m_b = nb;
    endtask

    // Drive one cycle's controls, then compare every output at the falling edge.
    task automatic apply(input ctl_t c, input logic [31:0] rd, input logic rst);
        cur_c = c; cur_rd = rd; cur_rst = rst;
        reset = rst;
        PCWrite = c.pcw; PCWriteCond = c.pcwc; IorD = c.iord; MemRead = c.mr;
        MemWrite = c.mw; IRWrite = c.irw; MemtoReg = c.m2r; RegWrite = c.rw;
        RegDst = c.rdst; ALUSrcA = c.srca; PCSource = c.pcsrc; ALUOp = c.aluop;
        ALUSrcB = c.srcb;
        mem.mem_rdata = rd;
        e_res  = alu_model(c.aluop, m_ir[5:0], c.srca ? m_a : m_pc, operand_b(c.srcb));
        e_addr = c.iord ? m_aluout : m_pc;
        @(negedge clk);
        chk("mem_addr",  mem.mem_addr,  e_addr);
        chk("mem_wdata", mem.mem_wdata, m_b);
        chk("mem_re",    32'(mem.mem_re), 32'(c.mr));
        chk("mem_we",    32'(mem.mem_we), 32'(c.mw));
        chk("zero",      32'(zero), 32'(e_res == 0));
        chk("op",        32'(op), 32'(m_ir[31:26]));
        chk("pc",        pc, m_pc);
        chk("ir",        ir, m_ir);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic run(input ctl_t c, input logic [31:0] rd);
        apply(c, rd, 1'b0);
        tick();
    endtask

    task automatic fetch_decode(input logic [31:0] instr);
        run(S0, instr);
        run(S1, 32'h0);
    endtask

    task automatic rtype_and_store(input logic [31:0] instr, input logic [31:0] exp, input string name);
        fetch_decode(instr);
        run(S6, 32'h0);
        run(S7, 32'h0);
        fetch_decode({OP_SW, 5'd0, 5'd6, 16'h0000});
        run(S2, 32'h0);
        apply(S5, 32'h0, 1'b0);
        chk(name, mem.mem_wdata, exp);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite} = '0;
        {MemtoReg, RegWrite, RegDst, ALUSrcA} = '0;
        PCSource = '0; ALUOp = '0; ALUSrcB = '0;
        mem.mem_rdata = '0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset for two cycles with writes requested; none may land.
        apply(SRW, 32'hDEAD_BEEF, 1'b1); tick();
        apply(SRW, 32'h1234_5678, 1'b1); tick();
        chk("reset_pc", pc, 32'h0);
        chk("reset_ir", ir, 32'h0);
        chk("reset_op", 32'(op), 32'h0);

        // lw $2,4($1) and lw $3,8($1)
        apply(S0, 32'h8C22_0004, 1'b0);
        chk("reset_mem_addr", mem.mem_addr, 32'h0);
        tick();
        chk("fetch_ir", ir, 32'h8C22_0004);
        chk("fetch_op", 32'(op), 32'(OP_LW));
        chk("fetch_pc", pc, 32'h4);
        run(S1, 32'h0);
        run(S2, 32'h0);
        apply(S3, 32'd5, 1'b0);
        chk("lw1_addr", mem.mem_addr, 32'h4);
        tick();
        run(S4, 32'h0);
        fetch_decode(32'h8C23_0008);
        run(S2, 32'h0);
        apply(S3, 32'd7, 1'b0);
        chk("lw2_addr", mem.mem_addr, 32'h8);
        tick();
        run(S4, 32'h0);

        rtype_and_store(32'h0043_3020, 32'd12,          "add_result");
        rtype_and_store(32'h0043_3022, 32'hFFFF_FFFE,   "sub_result");
        rtype_and_store(32'h0043_302A, 32'd1,           "slt_result");

        // beq taken from pc=8, then not taken
        fetch_decode(32'h0800_0002);
        run(S9, 32'h0);
        chk("j_to_8", pc, 32'h8);
        fetch_decode(32'h1042_0003);
        run(S8, 32'h0);
        chk("beq_taken", pc, 32'd24);
        fetch_decode(32'h0800_0002);
        run(S9, 32'h0);
        fetch_decode(32'h1043_0003);
        run(S8, 32'h0);
        chk("beq_not_taken", pc, 32'd12);

        // sw $2,8($0)
        fetch_decode(32'hAC02_0008);
        run(S2, 32'h0);
        apply(S5, 32'h0, 1'b0);
        chk("sw_addr",  mem.mem_addr, 32'h8);
        chk("sw_wdata", mem.mem_wdata, 32'd5);
        chk("sw_we",    32'(mem.mem_we), 32'd1);
        tick();

        // add $0,$2,$3 must leave register 0 at zero
        fetch_decode(32'h0043_0020);
        run(S6, 32'h0);
        run(S7, 32'h0);
        fetch_decode(32'hAC00_0000);
        run(S2, 32'h0);
        apply(S5, 32'h0, 1'b0);
        chk("r0_stays_zero", mem.mem_wdata, 32'h0);
        tick();

        // Move PC to 0x1000_0040 via a register, then jump within that region
        fetch_decode(32'h8C04_0000);
        run(S2, 32'h0);
        run(S3, 32'h1000_0040);
        run(S4, 32'h0);
        fetch_decode(32'h0080_0000);
        run(SPC, 32'h0);
        chk("pc_load", pc, 32'h1000_0040);
        fetch_decode(32'h0800_0010);
        run(S9, 32'h0);
        chk("jump_region", pc, 32'h1000_0040);

        // Random control traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            ctl_t rc;
            rc = ctl_t'(16'($urandom()));
            apply(rc, $urandom(), ($urandom_range(0, 63) == 0));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
